truth_table_sweeper: RTL and testbench

//  Sequencer that characterises one 3-input combinational gate (e.g. the 0xD4 function) by sweeping
//  all 8 input rows, waiting a settle time per row, sampling the gate output and assembling an 8-bit

---
 rtl/truth_table_pkg.sv | 19 +
 rtl/tt_settle_timer.sv | 40 ++++
 rtl/truth_table_sweeper.sv | 126 ++++++++++++
 tb/tb_truth_table_sweeper.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/truth_table_pkg.sv
// rtl/truth_table_pkg.sv - shared types and constants for the truth-table sweeper
package truth_table_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } state_t;

    localparam int N_ROWS = 8;
    localparam int TT_W   = 8;

    // Row 000 lands in the MSB so the code reads like a standard truth-table hex value.
    function automatic logic [2:0] row_bit_pos(input logic [2:0] row);
        return 3'(N_ROWS - 1) - row;
    endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// rtl/tt_settle_timer.sv - load/count-down timer that flags the last settle cycle
module tt_settle_timer #(
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic expire
);

    generate
        if (SETTLE_CYCLES < 1) begin : g_bad_settle
            $error("SETTLE_CYCLES must be at least 1");
        end
        if ((2 ** CNT_W) < SETTLE_CYCLES) begin : g_bad_width
            $error("CNT_W too narrow for SETTLE_CYCLES");
        end
    endgenerate

    // Loading SETTLE_CYCLES-1 makes expire fire on the SETTLE_CYCLES-th enabled cycle.
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(SETTLE_CYCLES - 1);

    logic [CNT_W-1:0] count;

    // Count down while enabled; a load always wins so back-to-back rows restart cleanly.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= LOAD_VAL;
        end else if (en && (count != '0)) begin
            count <= count - CNT_W'(1);
        end
    end

    assign expire = en && (count == '0);

endmodule

// File: rtl/truth_table_sweeper.sv
// rtl/truth_table_sweeper.sv - sweeps a 3-input gate through all rows and grades its truth table
module truth_table_sweeper
    import truth_table_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 3
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [TT_W-1:0] expected,
    output logic            dut_in1,
    output logic            dut_in2,
    output logic            dut_in3,
    input  logic            dut_out,
    output logic            busy,
    output logic            done,
    output logic [TT_W-1:0] tt_out,
    output logic            pass,
    output logic [TT_W-1:0] mismatch_mask
);

    state_t          state;
    state_t          state_next;
    logic [2:0]      row;
    logic [TT_W-1:0] capture;
    logic [TT_W-1:0] capture_next;
    logic [TT_W-1:0] exp_q;
    logic            start_ok;
    logic            timer_load;
    logic            timer_expire;
    logic            last_row;

    assign last_row = (row == 3'(N_ROWS - 1));

    tt_settle_timer #(
        .SETTLE_CYCLES(SETTLE_CYCLES),
        .CNT_W        (CNT_W)
    ) u_settle_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (timer_load),
        .en    (state == ST_SETTLE),
        .expire(timer_expire)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; start is only honoured when no sweep is in flight.
    always_comb begin
        state_next = state;
        start_ok   = 1'b0;
        timer_load = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    start_ok   = 1'b1;
                    timer_load = 1'b1;
                    state_next = ST_SETTLE;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            ST_SETTLE: begin
                if (timer_expire) begin
                    state_next = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                if (last_row) begin
                    state_next = ST_DONE;
                end else begin
                    timer_load = 1'b1;
                    state_next = ST_SETTLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Capture register with the current sample merged in, so DONE sees the final row.
    always_comb begin
        capture_next = capture;
        capture_next[row_bit_pos(row)] = dut_out;
    end

    // Row counter, capture and registered results.
    always_ff @(posedge clk) begin
        if (rst) begin
            row           <= '0;
            capture       <= '0;
            exp_q         <= '0;
            tt_out        <= '0;
            pass          <= 1'b0;
            mismatch_mask <= '0;
        end else if (start_ok) begin
            row           <= '0;
            capture       <= '0;
            exp_q         <= expected;
            tt_out        <= '0;
            pass          <= 1'b0;
            mismatch_mask <= '0;
        end else if (state == ST_SAMPLE) begin
            capture <= capture_next;
            if (last_row) begin
                tt_out        <= capture_next;
                pass          <= (capture_next == exp_q);
                mismatch_mask <= capture_next ^ exp_q;
            end else begin
                row <= row + 3'd1;
            end
        end
    end

    assign busy                        = (state == ST_SETTLE) || (state == ST_SAMPLE);
    assign done                        = (state == ST_DONE);
    assign {dut_in1, dut_in2, dut_in3} = busy ? row : 3'b000;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb/tb_truth_table_sweeper.sv - randomized and directed self-checking bench for truth_table_sweeper
module tb_truth_table_sweeper;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] expected = 8'h00;

    logic       a_in1, a_in2, a_in3, a_busy, a_done, a_pass;
    logic [7:0] a_tt, a_mask;
    logic       b_in1, b_in2, b_in3, b_busy, b_done, b_pass;
    logic [7:0] b_tt, b_mask;

    logic [2:0] din    [2];
    logic       busy_o [2];
    logic       done_o [2];
    logic [7:0] tt_o   [2];
    logic       pass_o [2];
    logic [7:0] mask_o [2];
    logic       gout   [2];

    logic [7:0] fn [2] = '{8'hD4, 8'hD4};
    int         dl [2] = '{0, 2};
    logic [2:0] hist [2][4];

    int         mk    [2] = '{-1, -1};
    logic [7:0] mexp  [2];
    logic [7:0] mcode [2];
    logic [7:0] mtt   [2] = '{8'h00, 8'h00};
    logic       mpass [2] = '{1'b0, 1'b0};
    logic [7:0] mmask [2] = '{8'h00, 8'h00};

    int n_checks = 0;
    int n_err    = 0;
    bit chk_en   = 1'b0;

    always #5 clk = ~clk;

    truth_table_sweeper #(.SETTLE_CYCLES(4), .CNT_W(3)) dut (
        .clk(clk), .rst(rst), .start(start), .expected(expected),
        .dut_in1(a_in1), .dut_in2(a_in2), .dut_in3(a_in3), .dut_out(gout[0]),
        .busy(a_busy), .done(a_done), .tt_out(a_tt), .pass(a_pass), .mismatch_mask(a_mask)
    );

    truth_table_sweeper #(.SETTLE_CYCLES(1), .CNT_W(1)) dut_s1 (
        .clk(clk), .rst(rst), .start(start), .expected(expected),
        .dut_in1(b_in1), .dut_in2(b_in2), .dut_in3(b_in3), .dut_out(gout[1]),
        .busy(b_busy), .done(b_done), .tt_out(b_tt), .pass(b_pass), .mismatch_mask(b_mask)
    );

    assign din[0] = {a_in1, a_in2, a_in3};
    assign din[1] = {b_in1, b_in2, b_in3};
    assign busy_o[0] = a_busy;  assign busy_o[1] = b_busy;
    assign done_o[0] = a_done;  assign done_o[1] = b_done;
    assign tt_o[0]   = a_tt;    assign tt_o[1]   = b_tt;
    assign pass_o[0] = a_pass;  assign pass_o[1] = b_pass;
    assign mask_o[0] = a_mask;  assign mask_o[1] = b_mask;

    function automatic int s_of(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    function automatic int dk_of(input int i);
        return 8 * (s_of(i) + 1) + 1;
    endfunction

    function automatic logic gate_eval(input logic [7:0] f, input logic [2:0] x);
        return f[7 - x];
    endfunction

    // Row visible on the gate inputs in sweep-relative cycle c (0 outside a sweep).
    function automatic int row_at(input int s, input int c);
        return (c >= 1 && c <= 8 * (s + 1)) ? (c - 1) / (s + 1) : 0;
    endfunction

    // Code a sweep must measure for gate f whose output lags its inputs by d cycles.
    function automatic logic [7:0] sweep_code(input int s, input logic [7:0] f, input int d);
        logic [7:0] code;
        code = 8'h00;
        for (int r = 0; r < 8; r++) begin
            code[7 - r] = f[7 - row_at(s, (r + 1) * (s + 1) - d)];
        end
        return code;
    endfunction

    // Gate models: pure function of current or delayed inputs.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            hist[i][0] <= din[i];
            for (int j = 1; j < 4; j++) hist[i][j] <= hist[i][j-1];
        end
    end

    assign gout[0] = gate_eval(fn[0], (dl[0] == 0) ? din[0] : hist[0][dl[0] - 1]);
    assign gout[1] = gate_eval(fn[1], (dl[1] == 0) ? din[1] : hist[1][dl[1] - 1]);

    // Reference model: cycle index since the accepted start, plus result registers.
    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                mk[i] <= -1;  mtt[i] <= 8'h00;  mpass[i] <= 1'b0;  mmask[i] <= 8'h00;
            end else if ((mk[i] == -1 || mk[i] == dk_of(i)) && start) begin
                mk[i]    <= 1;
                mexp[i]  <= expected;
                mcode[i] <= sweep_code(s_of(i), fn[i], dl[i]);
                mtt[i] <= 8'h00;  mpass[i] <= 1'b0;  mmask[i] <= 8'h00;
            end else if (mk[i] >= 1 && mk[i] < dk_of(i)) begin
                mk[i] <= mk[i] + 1;
                if (mk[i] + 1 == dk_of(i)) begin
                    mtt[i]   <= mcode[i];
                    mpass[i] <= (mcode[i] == mexp[i]);
                    mmask[i] <= mcode[i] ^ mexp[i];
                end
            end else begin
                mk[i] <= -1;
            end
        end
    end

    task automatic check(input string nm, input int idx, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[%0d] at %0t: got %0h expected %0h", nm, idx, $time, act, exp);
        end
    endtask

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                check("dut_in", i, 16'(din[i]), 16'(row_at(s_of(i), mk[i])));
                check("busy", i, 16'(busy_o[i]), 16'(mk[i] >= 1 && mk[i] < dk_of(i)));
                check("done", i, 16'(done_o[i]), 16'(mk[i] == dk_of(i)));
                check("tt_out", i, 16'(tt_o[i]), 16'(mtt[i]));
                check("pass", i, 16'(pass_o[i]), 16'(mpass[i]));
                check("mismatch_mask", i, 16'(mask_o[i]), 16'(mmask[i]));
            end
        end
    end

    // One start pulse; returns the cycle done rises on each instance (-1 if never).
    task automatic do_sweep(input logic [7:0] e, output int dcyc_a, output int dcyc_b);
        expected = e;
        start    = 1'b1;
        dcyc_a   = -1;
        dcyc_b   = -1;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
            if (c <= 40 && ((c - 1) % 5 == 0 || c % 5 == 0))
                check("row_literal", c, 16'(din[0]), 16'((c - 1) / 5));
            if (done_o[1] && dcyc_b < 0) dcyc_b = c;
            if (done_o[0]) begin
                dcyc_a = c;
                break;
            end
        end
        @(negedge clk);
        check("idle_in_after_done", 0, 16'(din[0]), 16'h0);
    endtask

    int  ca, cb, first_done, second_done, n_done;
    bit  saw_done;

    initial begin
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("reset_tt", 0, 16'(a_tt), 16'h0);
        check("reset_busy", 0, 16'(a_busy), 16'h0);
        check("reset_done", 0, 16'(a_done), 16'h0);
        check("reset_din", 0, 16'(din[0]), 16'h0);
        rst = 1'b0;
        @(negedge clk);

        // Matching expected: D4 passes on S=4; S=1 with a 2-cycle gate lags one row.
        do_sweep(8'hD4, ca, cb);
        check("done_cycle_s4", 0, 16'(ca), 16'd41);
        check("done_cycle_s1", 1, 16'(cb), 16'd17);
        check("tt_s4", 0, 16'(a_tt), 16'hD4);
        check("pass_s4", 0, 16'(a_pass), 16'h1);
        check("mask_s4", 0, 16'(a_mask), 16'h00);
        check("tt_s1_delayed", 1, 16'(b_tt), 16'hEA);
        check("pass_s1_delayed", 1, 16'(b_pass), 16'h0);
        check("mask_s1_delayed", 1, 16'(b_mask), 16'h3E);
        check("model_tt_s1", 1, 16'(mtt[1]), 16'hEA);
        repeat (3) @(negedge clk);

        // Wrong expected code flags only the LSB row.
        do_sweep(8'hD5, ca, cb);
        check("tt_d5", 0, 16'(a_tt), 16'hD4);
        check("pass_d5", 0, 16'(a_pass), 16'h0);
        check("mask_d5", 0, 16'(a_mask), 16'h01);
        repeat (3) @(negedge clk);

        // Same 2-cycle delayed gate on S=4 still settles in time.
        dl[0] = 2;
        do_sweep(8'hD4, ca, cb);
        check("pass_s4_delayed", 0, 16'(a_pass), 16'h1);
        dl[0] = 0;
        repeat (3) @(negedge clk);

        // Start held high: one done per sweep, restart straight out of DONE.
        expected    = 8'hD4;
        start       = 1'b1;
        first_done  = -1;
        second_done = -1;
        n_done      = 0;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (c == 42) begin
                check("restart_busy", 0, 16'(a_busy), 16'h1);
                check("restart_cleared_tt", 0, 16'(a_tt), 16'h0);
            end
            if (done_o[0]) begin
                n_done++;
                if (first_done < 0) first_done = c;
                else begin
                    second_done = c;
                    break;
                end
            end
        end
        start = 1'b0;
        check("held_first_done", 0, 16'(first_done), 16'd41);
        check("held_second_done", 0, 16'(second_done), 16'd82);
        check("held_done_count", 0, 16'(n_done), 16'd2);
        repeat (25) @(negedge clk);

        // Reset mid-sweep aborts silently.
        expected = 8'hD4;
        start    = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (c == 1) start = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_din", 0, 16'(din[0]), 16'h0);
        check("abort_busy", 0, 16'(a_busy), 16'h0);
        check("abort_done", 0, 16'(a_done), 16'h0);
        check("abort_tt", 0, 16'(a_tt), 16'h0);
        check("abort_pass", 0, 16'(a_pass), 16'h0);
        check("abort_mask", 0, 16'(a_mask), 16'h0);
        saw_done = 1'b0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (a_done) saw_done = 1'b1;
        end
        check("abort_no_done", 0, 16'(saw_done), 16'h0);

        // Random gates, expected codes, starts (including while busy) and rare resets.
        for (int c = 0; c < 3000; c++) begin
            if (!(mk[0] >= 1 && mk[0] < dk_of(0)) && $urandom_range(0, 3) == 0) begin
                fn[0] = 8'($urandom);
                dl[0] = $urandom_range(0, 4);
            end
            if ($urandom_range(0, 7) == 0)
                expected = ($urandom_range(0, 1) == 1) ? fn[0] : 8'($urandom);
            start = ($urandom_range(0, 5) == 0);
            rst   = ($urandom_range(0, 299) == 0);
            @(negedge clk);
        end
        start = 1'b0;
        rst   = 1'b0;
        repeat (60) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
